muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit beside the single-cycle ALU; the datapath

---
 rtl/muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Latency: Done DATA_WIDTH+1 cycles after the accept edge (one cycle when early-out fires).
// Backpressure: none; Start is sampled only in IDLE, requests while Busy/Done are dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Start, Funct3         request and RV32M operation select
//                         (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                          100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   SrcA, SrcB            rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   Busy                  high while iterating
//   Done                  one-cycle pulse, MDResult valid
//   MDResult              result, held until the next operation finishes
//
// Build option:
//   MULDIV_EARLY_OUT_EN   when defined, divide-by-zero, signed divide overflow and
//                         multiply-by-zero finish straight from IDLE (Done one cycle
//                         after accept, Busy never raised). Results are identical.

module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int FUNCT3_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Start,
  input  logic [FUNCT3_LENGTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    MDResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ------------------------------------------------------------------
  // Operation state captured on the accept edge
  // ------------------------------------------------------------------
  logic [CW-1:0]  r_cnt;      // step counter, 0 .. W-1
  logic [2*W-1:0] r_acc;      // {partial product | remainder, multiplier | dividend/quotient}
  logic [W-1:0]   r_opb;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic           r_is_div;
  logic           r_is_rem;   // div only: return remainder instead of quotient
  logic           r_hi;       // mul only: return upper half of product
  logic           r_neg;      // negate the magnitude result at the end
  logic           r_div0;     // divisor was zero
  logic [W-1:0]   r_result;

  // ------------------------------------------------------------------
  // Input decode (used only on the accept edge)
  // ------------------------------------------------------------------
  logic [2:0]   w_f3;
  logic         w_in_div;
  logic         w_a_signed;
  logic         w_b_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic         w_neg_res;
  logic         w_b_zero;
  logic         w_accept;
  logic         w_early;

  assign w_f3     = Funct3[2:0];
  assign w_in_div = w_f3[2];

  // Divide: DIV/REM signed, DIVU/REMU unsigned.
  // Multiply: rs1 signed for MUL/MULH/MULHSU, rs2 signed for MUL/MULH.
  // MUL keeps only the low half, which is sign-agnostic, so treating it as s x s is safe.
  assign w_a_signed = w_in_div ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
  assign w_b_signed = w_in_div ? ~w_f3[0] : ~w_f3[1];

  assign w_a_neg = w_a_signed & SrcA[W-1];
  assign w_b_neg = w_b_signed & SrcB[W-1];
  assign w_a_mag = w_a_neg ? (~SrcA + W'(1)) : SrcA;
  assign w_b_mag = w_b_neg ? (~SrcB + W'(1)) : SrcB;

  // Remainder follows the dividend's sign; everything else follows the sign product.
  assign w_neg_res = (w_in_div && w_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_b_zero = (SrcB == '0);
  assign w_accept = (r_state == S_IDLE) && Start;

`ifdef MULDIV_EARLY_OUT_EN
  logic         w_div_ovf;
  logic         w_mul_zero;
  logic [W-1:0] w_special_res;

  assign w_div_ovf  = w_in_div && !w_f3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
  assign w_mul_zero = !w_in_div && ((SrcA == '0) || w_b_zero);
  assign w_early    = (w_in_div && w_b_zero) || w_div_ovf || w_mul_zero;

  always_comb begin
    w_special_res = '0;
    if (w_in_div && w_b_zero) begin
      w_special_res = w_f3[1] ? SrcA : '1;
    end else if (w_div_ovf) begin
      w_special_res = w_f3[1] ? '0 : MIN_NEG;
    end
  end
`else
  assign w_early = 1'b0;
`endif

  // ------------------------------------------------------------------
  // One radix-2 step
  // ------------------------------------------------------------------
  // Multiply: add multiplicand into the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right by one. After W steps
  // r_acc holds the full 2W-bit product of magnitudes.
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: shift the next dividend bit into the partial remainder and subtract
  // the divisor if it fits; the quotient bit enters at the bottom of r_acc.
  // A zero divisor always "fits", which leaves an all-ones quotient and the
  // dividend magnitude as remainder.
  logic [W:0]     w_div_shift;
  logic           w_div_ok;
  logic [W-1:0]   w_div_diff;
  logic [2*W-1:0] w_div_next;

  assign w_div_shift = r_acc[2*W-1:W-1];
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[W-1:0] - r_opb;
  assign w_div_next  = {(w_div_ok ? w_div_diff : w_div_shift[W-1:0]),
                        r_acc[W-2:0], w_div_ok};

  logic [2*W-1:0] w_acc_next;
  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  // ------------------------------------------------------------------
  // Final result from the last step's accumulator
  // ------------------------------------------------------------------
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_mul_res;
  logic [W-1:0]   w_div_sel;
  logic [W-1:0]   w_div_res;
  logic [W-1:0]   w_final;

  assign w_prod    = r_neg ? (~w_acc_next + (2*W)'(1)) : w_acc_next;
  assign w_mul_res = r_hi ? w_prod[2*W-1:W] : w_prod[W-1:0];

  assign w_div_sel = r_is_rem ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0];

  // Signed overflow (-2^(W-1) / -1) needs no special case: quotient magnitude
  // 2^(W-1) negates back onto itself and the remainder is zero. Division by
  // zero only needs the quotient forced, since the negated remainder is SrcA.
  always_comb begin
    w_div_res = r_neg ? (~w_div_sel + W'(1)) : w_div_sel;
    if (r_div0 && !r_is_rem) begin
      w_div_res = '1;
    end
  end

  assign w_final = r_is_div ? w_div_res : w_mul_res;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_next = w_early ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      S_RUN:    Busy = 1'b1;
      S_FINISH: Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_hi     <= 1'b0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= w_in_div;
      r_is_rem <= w_f3[1];
      r_hi     <= (w_f3[1:0] != 2'b00);
      r_neg    <= w_neg_res;
      r_div0   <= w_in_div && w_b_zero;
      r_opb    <= w_in_div ? w_b_mag : w_a_mag;
      r_acc    <= {{W{1'b0}}, (w_in_div ? w_a_mag : w_b_mag)};
`ifdef MULDIV_EARLY_OUT_EN
      if (w_early) begin
        r_result <= w_special_res;
      end
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      if (r_cnt == CNT_LAST) begin
        r_result <= w_final;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign MDResult = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] MDResult;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .MDResult(MDResult)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (f[2]) special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      special = (a == 0) || (b == 0);
    return (EARLY && special) ? 1 : 33;
  endfunction

  // Issues one operation starting at the next falling edge. Cycle 1 is the
  // cycle right after the accept edge; lat is the cycle in which Done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output logic busy1, output logic busyd);
    @(negedge clk);
    Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    busy1 = Busy;
    busyd = 1'b1;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (Done) begin
        lat = n; busyd = Busy; res = MDResult;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] res, held, exp_r;
    logic        b1, bd;
    int          lat, done_cnt, first;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB}; // MUL 7 x -3
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}; // MULHU
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}; // MULH -1 x -1
    vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD}; // DIV -7/2
    vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF}; // REM -7/2
    vecs[5]  = '{3'd5, 32'd100,       32'd7,         32'd14};        // DIVU
    vecs[6]  = '{3'd7, 32'd100,       32'd7,         32'd2};         // REMU
    vecs[7]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF}; // DIV /0
    vecs[8]  = '{3'd6, 32'd5,         32'd0,         32'd5};         // REM /0
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}; // DIV overflow
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}; // REM overflow
    vecs[11] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; // MULHSU -1 x (2^32-1)
    vecs[12] = '{3'd0, 32'd0,         32'd12345,     32'd0};         // MUL by zero
    vecs[13] = '{3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF}; // DIVU /0
    vecs[14] = '{3'd7, 32'h8000_0001, 32'd0,         32'h8000_0001}; // REMU /0
    vecs[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000}; // MULH min x min
    vecs[16] = '{3'd4, 32'h8000_0000, 32'd2,         32'hC000_0000}; // DIV min/2
    vecs[17] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF}; // REM -7/-2
    vecs[18] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD}; // DIV 7/-2
    vecs[19] = '{3'd3, 32'h8000_0000, 32'd4,         32'h0000_0002}; // MULHU

    // Reset state
    #1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_result", MDResult, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, b1, bd);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
      check($sformatf("vec%0d_busy_c1", i), {31'd0, b1},
            {31'd0, (exp_lat(vecs[i].f, vecs[i].a, vecs[i].b) != 1)});
      check($sformatf("vec%0d_busy_done", i), {31'd0, bd}, 32'd0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(f, a, b, res, lat, b1, bd);
      check($sformatf("rnd%0d_f%0d_result", i, f), res, ref_model(f, a, b));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat(f, a, b)));
    end

    // Start pulses during RUN (cycles 5, 20) and during FINISH are dropped
    exp_r = ref_model(3'd0, 32'd123456, 32'd789);
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd123456; SrcB = 32'd789;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    done_cnt = 0; first = -1; held = 32'hDEAD_BEEF;
    for (int n = 1; n <= 75; n++) begin
      if (n > 1) @(negedge clk);
      Start = 1'b0;
      if (Done) begin
        done_cnt++;
        if (first < 0) begin first = n; held = MDResult; end
      end
      if (n == 34) begin
        check("finish_start_busy", {31'd0, Busy}, 32'd0);
        check("finish_start_held", MDResult, exp_r);
      end
      if (n == 5 || n == 20 || (Done && first == n)) begin
        Start = 1'b1; Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
      end
    end
    Start = 1'b0;
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_done_cycle", 32'(first), 32'd33);
    check("ignore_result", held, exp_r);

    // Reset mid-operation
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("midop_busy", {31'd0, Busy}, 32'd1);
    check("midop_result_held", MDResult, exp_r);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_result", MDResult, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(3'd5, 32'd100, 32'd7, res, lat, b1, bd);
    check("after_abort_result", res, 32'd14);
    check("after_abort_latency", 32'(lat), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
